// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared FSM state encoding and AXI response codes
package bram_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RD_A  = 3'd3,
        RD_D  = 3'd4
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/bram_axi_arbiter_if.sv
// rtl/bram_axi_arbiter_if.sv - AXI master bus between the arbiter and the BRAM controller
interface bram_axi_arbiter_if #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 12
);
    logic [ADDRESS_SIZE-1:0]  m_awaddr;
    logic                     m_awvalid;
    logic                     m_awready;
    logic [DATA_SIZE-1:0]     m_wdata;
    logic [DATA_SIZE/8-1:0]   m_wstrb;
    logic                     m_wvalid;
    logic                     m_wready;
    logic [1:0]               m_bresp;
    logic                     m_bvalid;
    logic                     m_bready;
    logic [ADDRESS_SIZE-1:0]  m_araddr;
    logic                     m_arvalid;
    logic                     m_arready;
    logic [DATA_SIZE-1:0]     m_rdata;
    logic [1:0]               m_rresp;
    logic                     m_rvalid;
    logic                     m_rready;

    modport master (
        output m_awaddr, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input m_bresp, m_bvalid, output m_bready,
        output m_araddr, m_arvalid, input m_arready,
        input m_rdata, m_rresp, m_rvalid, output m_rready
    );

    modport slave (
        input m_awaddr, m_awvalid, output m_awready,
        input m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input m_araddr, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant with priority pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant,
    output logic       valid
);

    logic ptr_q, ptr_d;

    always_comb begin
        valid = |req;
        grant = ptr_q;
        if (!req[ptr_q]) begin
            grant = ~ptr_q;
        end
        ptr_d = ptr_q;
        // the loser of this grant gets priority next time
        if (advance && valid) begin
            ptr_d = ~grant;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bram_axi_arbiter.sv
// rtl/bram_axi_arbiter.sv - two-port requester arbiter driving a single AXI master, one access in flight
module bram_axi_arbiter
    import bram_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 12
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [1:0]                    req,
    input  logic [1:0]                    we,
    input  logic [2*ADDRESS_SIZE-1:0]     addr,
    input  logic [2*DATA_SIZE-1:0]        wdata,
    input  logic [2*(DATA_SIZE/8)-1:0]    wstrb,
    output logic [1:0]                    done,
    output logic [DATA_SIZE-1:0]          rdata,
    output logic [1:0]                    resp,
    bram_axi_arbiter_if.master            m
);

    localparam int STRB_SIZE = DATA_SIZE / 8;

    state_e                  state_q, state_d;
    logic                    gnt_q, gnt_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
    logic [STRB_SIZE-1:0]    wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    arb_grant, arb_valid;
    logic                    unused_awready;

    // AW completion carries no information here; the W handshake closes the request phase
    assign unused_awready = m.m_awready;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .advance (state_q == IDLE),
        .grant   (arb_grant),
        .valid   (arb_valid)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        done      = 2'b00;
        rdata     = '0;
        resp      = OKAY;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_grant;
                    addr_d  = arb_grant ? addr[2*ADDRESS_SIZE-1:ADDRESS_SIZE] : addr[ADDRESS_SIZE-1:0];
                    wdata_d = arb_grant ? wdata[2*DATA_SIZE-1:DATA_SIZE] : wdata[DATA_SIZE-1:0];
                    wstrb_d = arb_grant ? wstrb[2*STRB_SIZE-1:STRB_SIZE] : wstrb[STRB_SIZE-1:0];
                    if (we[arb_grant]) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (m.m_wready) begin
                    state_d   = WRESP;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b1;
                end
            end
            WRESP: begin
                if (m.m_bvalid) begin
                    state_d     = IDLE;
                    bready_d    = 1'b0;
                    done[gnt_q] = 1'b1;
                    resp        = m.m_bresp;
                end
            end
            RD_A: begin
                if (m.m_arready) begin
                    state_d   = RD_D;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_D: begin
                if (m.m_rvalid) begin
                    state_d     = IDLE;
                    rready_d    = 1'b0;
                    done[gnt_q] = 1'b1;
                    rdata       = m.m_rdata;
                    resp        = m.m_rresp;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign m.m_awvalid = awvalid_q;
    assign m.m_wvalid  = wvalid_q;
    assign m.m_bready  = bready_q;
    assign m.m_arvalid = arvalid_q;
    assign m.m_rready  = rready_q;
    assign m.m_awaddr  = awvalid_q ? addr_q  : '0;
    assign m.m_wdata   = wvalid_q  ? wdata_q : '0;
    assign m.m_wstrb   = wvalid_q  ? wstrb_q : '0;
    assign m.m_araddr  = arvalid_q ? addr_q  : '0;

endmodule

// File: doc/bram_axi_arbiter.md
BRAM_AXI_ARBITER -- requirements
Module: bram_axi_arbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, giving the data width (byte lanes = DATA_SIZE/8).
REQ-002 SHALL have parameter ADDRESS_SIZE, default 12, giving the word address width.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-requester request; bit i is requester i.
REQ-006 we  input  2  per-requester write (1) / read (0).
REQ-007 addr  input  2*ADDRESS_SIZE  per-requester address; requester i uses slice i.
REQ-008 wdata  input  2*DATA_SIZE  per-requester write data.
REQ-009 wstrb  input  2*DATA_SIZE/8  per-requester byte strobes.
REQ-010 done  output  2  one-cycle completion pulse per requester.
REQ-011 rdata  output  DATA_SIZE  read data; valid while a done bit is high.
REQ-012 resp  output  2  AXI response of the completed access; valid while a done bit is high.
REQ-013 m_awaddr / m_awvalid / m_awready  out / out / in  ADDRESS_SIZE / 1 / 1  AXI write address channel.
REQ-014 m_wdata / m_wstrb / m_wvalid / m_wready  out / out / out / in  DATA_SIZE / DATA_SIZE/8 / 1 / 1  AXI write data channel.
REQ-015 m_bresp / m_bvalid / m_bready  in / in / out  2 / 1 / 1  AXI write response channel.
REQ-016 m_araddr / m_arvalid / m_arready  out / out / in  ADDRESS_SIZE / 1 / 1  AXI read address channel.
REQ-017 m_rdata / m_rresp / m_rvalid / m_rready  in / in / in / out  DATA_SIZE / 2 / 1 / 1  AXI read data channel.

Function
REQ-018 FSM states SHALL be IDLE, WR, WRESP, RD_A and RD_D, with one transaction in flight at a time.
REQ-019 In IDLE with any req bit high, the block SHALL grant one requester, latch its we/addr/wdata/wstrb, and move to WR (we=1) or RD_A (we=0) on the next edge.
REQ-020 Arbitration SHALL be round-robin: a priority pointer (reset 0) favours requester ptr; after each grant ptr becomes the non-granted index; with a single requester active, that requester wins.
REQ-021 WR: m_awvalid and m_wvalid SHALL assert together from the latched values, both held until the W handshake (m_wvalid & m_wready); extra AW handshakes in between SHALL be ignored; then go to WRESP.
REQ-022 WRESP: m_bready SHALL be 1; on m_bvalid, pulse done[grant], drive resp=m_bresp and rdata=0, and return to IDLE.
REQ-023 RD_A: m_arvalid SHALL be held until m_arvalid & m_arready, then go to RD_D.
REQ-024 RD_D: m_rready SHALL be 1; on m_rvalid, pulse done[grant], drive rdata=m_rdata and resp=m_rresp, and return to IDLE.
REQ-025 A new grant SHALL NOT occur in the cycle done pulses; the earliest next grant is the following cycle (IDLE).
REQ-026 req, addr and data changes after a grant SHALL NOT affect the in-flight transaction; if req is dropped mid-transaction, the transaction still completes and done still pulses.
REQ-027 At most one done bit SHALL be high in any cycle; done is 0 in all states except the completion cycle.
REQ-028 m_* valid/ready outputs SHALL be registered and glitch-free; the address/data outputs SHALL be 0 when the corresponding valid is low.

Reset
REQ-029 On reset_n low, immediately and regardless of state: FSM=IDLE, ptr=0, done=0, rdata=0, resp=0, and all m_* valid/ready and address/data outputs = 0.
REQ-030 A transaction interrupted by reset SHALL be discarded, with no done pulse after reset release.

Structure
REQ-031 The FSM state encoding and the AXI response constants (OKAY=2'b00, SLVERR=2'b10) SHALL reside in the shared package bram_pkg.
REQ-032 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], advance; outputs grant index and valid).

Verification
REQ-033 Req0 write addr 0x010, wdata 0xDEADBEEF, wstrb 0xF; then req0 read 0x010 -> done[0] pulses twice; the read gives rdata=0xDEADBEEF, resp=00.
REQ-034 Req0 and req1 both high in the same cycle from reset -> requester 0 is served first, then requester 1; with both held high, grants alternate 0,1,0,1.
REQ-035 Req1 write 0x020 data 0x11223344 wstrb 0x3 over prior 0xFFFFFFFF; then read -> rdata=0xFFFF3344.
REQ-036 Req0 read granted, then req0 deasserted and addr changed -> the original address is read and done[0] still pulses once.
REQ-037 reset_n asserted during WRESP and during RD_D -> all outputs 0 the same cycle; no done pulse after release; the next request completes normally.
REQ-038 A slave model that delays m_bvalid/m_rvalid by 5 cycles -> valids are held, no early done pulse, and m_bready/m_rready are high throughout.
